// File: rtl/fetch_unit.sv
// Instruction fetch stage feeding the control unit.
// Owns the 12-bit program counter, fetches 16-bit words over a req/ack
// handshake, issues each word for exactly one cycle, then waits for the
// control unit's registered jump decision before starting the next fetch.
module fetch_unit #(
  parameter int          WAIT_CYCLES = 1,
  parameter logic [15:0] BUBBLE      = 16'h0000,
  parameter logic [11:0] RESET_PC    = 12'h000
) (
  input  logic        clk,
  input  logic        rst,
  output logic [11:0] rom_addr,
  output logic        rom_req,
  input  logic        rom_ack,
  input  logic [15:0] rom_data,
  output logic [15:0] instruction,
  output logic        instr_valid,
  input  logic        must_jump,
  input  logic [11:0] jump_addr,
  input  logic        halt,
  output logic [11:0] pc,
  output logic        halted
);

  // Wait counter only has to hold WAIT_CYCLES-1; keep at least one bit.
  localparam int               CNT_W    = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WAIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [1:0] {
    S_FETCH  = 2'd0,
    S_ISSUE  = 2'd1,
    S_WAIT   = 2'd2,
    S_HALTED = 2'd3
  } state_t;

  // Registered state and outputs.
  state_t           r_state;
  logic [11:0]      r_pc;
  logic             r_req;
  logic             r_valid;
  logic             r_halted;
  logic [CNT_W-1:0] r_cnt;
  logic [15:0]      r_word;

  // Next-state values.
  state_t           w_state_nxt;
  logic [11:0]      w_pc_nxt;
  logic             w_req_nxt;
  logic             w_valid_nxt;
  logic             w_halted_nxt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             w_latch;
  logic             w_entry;

  // Next-state and next-output logic; w_entry marks an instruction boundary
  // where halt decides between starting a fetch and parking in HALTED.
  always_comb begin
    w_state_nxt  = r_state;
    w_pc_nxt     = r_pc;
    w_req_nxt    = r_req;
    w_valid_nxt  = 1'b0;
    w_halted_nxt = r_halted;
    w_cnt_nxt    = r_cnt;
    w_latch      = 1'b0;
    w_entry      = 1'b0;

    case (r_state)
      S_FETCH: begin
        if (!r_req) begin
          // Only reached right after reset: request not yet raised.
          w_entry = 1'b1;
        end else if (rom_ack) begin
          w_latch     = 1'b1;
          w_pc_nxt    = r_pc + 12'd1;
          w_req_nxt   = 1'b0;
          w_valid_nxt = 1'b1;
          w_state_nxt = S_ISSUE;
        end
      end
      S_ISSUE: begin
        w_cnt_nxt   = CNT_LOAD;
        w_state_nxt = S_WAIT;
      end
      S_WAIT: begin
        if (r_cnt == '0) begin
          // The one cycle where the control unit's jump is trusted.
          if (must_jump) begin
            w_pc_nxt = jump_addr;
          end
          w_entry = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt - CNT_ONE;
        end
      end
      S_HALTED: begin
        if (!halt) begin
          w_entry = 1'b1;
        end
      end
      default: begin
        w_state_nxt = S_FETCH;
        w_req_nxt   = 1'b0;
      end
    endcase

    // Raising the request on the transition itself keeps zero-wait memory
    // at one instruction per (2 + WAIT_CYCLES) cycles.
    if (w_entry) begin
      if (halt) begin
        w_state_nxt  = S_HALTED;
        w_req_nxt    = 1'b0;
        w_halted_nxt = 1'b1;
      end else begin
        w_state_nxt  = S_FETCH;
        w_req_nxt    = 1'b1;
        w_halted_nxt = 1'b0;
      end
    end
  end

  // Control state register with synchronous reset; a reset mid-handshake
  // simply drops the request so any late ack is ignored.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_FETCH;
      r_pc     <= RESET_PC;
      r_req    <= 1'b0;
      r_valid  <= 1'b0;
      r_halted <= 1'b0;
      r_cnt    <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_pc     <= w_pc_nxt;
      r_req    <= w_req_nxt;
      r_valid  <= w_valid_nxt;
      r_halted <= w_halted_nxt;
      r_cnt    <= w_cnt_nxt;
    end
  end

  // Instruction word holding register; data only, masked by r_valid at the output.
  always_ff @(posedge clk) begin
    if (w_latch) begin
      r_word <= rom_data;
    end
  end

  assign rom_addr    = r_pc;
  assign rom_req     = r_req;
  assign pc          = r_pc;
  assign halted      = r_halted;
  assign instr_valid = r_valid;
  assign instruction = r_valid ? r_word : BUBBLE;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: a transaction-level reference model
// (fetch outstanding / cycles since handshake / halted) checked every cycle,
// directed scenarios pinned with literal expectations, then random traffic.
module tb_fetch_unit;

  localparam int          W        = 1;
  localparam logic [15:0] BUBBLE   = 16'h0000;
  localparam logic [11:0] RESET_PC = 12'h000;
  localparam int          IDLE     = -1;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rom_ack = 1'b0;
  logic [15:0] rom_data = 16'h0000;
  logic        must_jump = 1'b0;
  logic [11:0] jump_addr = 12'h000;
  logic        halt = 1'b0;
  logic [11:0] rom_addr;
  logic        rom_req;
  logic [15:0] instruction;
  logic        instr_valid;
  logic [11:0] pc;
  logic        halted;

  fetch_unit #(.WAIT_CYCLES(W), .BUBBLE(BUBBLE), .RESET_PC(RESET_PC)) dut (
    .clk(clk), .rst(rst), .rom_addr(rom_addr), .rom_req(rom_req),
    .rom_ack(rom_ack), .rom_data(rom_data), .instruction(instruction),
    .instr_valid(instr_valid), .must_jump(must_jump), .jump_addr(jump_addr),
    .halt(halt), .pc(pc), .halted(halted)
  );

  always #5 clk = ~clk;

  logic [15:0] mem [4096];
  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int lat_mode = 0;
  int cur_lat = 0;
  int wcnt = 0;
  bit spur_en = 1'b0;

  // Reference model: what the fetch stage is doing, in instruction terms.
  typedef struct packed {
    logic [11:0] pc;
    logic        fetching;
    logic        halted;
    logic        boot;
    int          since;
    logic [15:0] word;
  } mstate_t;

  mstate_t m = '0;

  function automatic mstate_t model_next(mstate_t s);
    mstate_t n;
    bit start;
    n = s;
    start = 1'b0;
    if (rst) begin
      n.pc = RESET_PC; n.fetching = 1'b0; n.halted = 1'b0;
      n.boot = 1'b1; n.since = IDLE;
      return n;
    end
    if (s.since != IDLE) n.since = s.since + 1;
    if (s.boot) begin
      n.boot = 1'b0; start = 1'b1;
    end else if (s.halted) begin
      if (!halt) start = 1'b1;
    end else if (s.fetching) begin
      if (rom_ack) begin
        n.word = rom_data; n.pc = s.pc + 12'd1; n.fetching = 1'b0; n.since = 0;
      end
    end else if (s.since == W) begin
      if (must_jump) n.pc = jump_addr;
      n.since = IDLE; start = 1'b1;
    end
    if (start) begin
      if (halt) begin n.halted = 1'b1; n.fetching = 1'b0; end
      else      begin n.halted = 1'b0; n.fetching = 1'b1; end
    end
    return n;
  endfunction

  always @(posedge clk) m <= model_next(m);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int pick_lat();
    return (lat_mode < 0) ? int'($urandom_range(0, 4)) : lat_mode;
  endfunction

  task automatic set_lat(input int l);
    lat_mode = l;
    cur_lat  = pick_lat();
    wcnt     = 0;
  endtask

  // One cycle: compare at the falling edge, then drive the memory response.
  task automatic step();
    @(negedge clk);
    cyc++;
    chk("rom_req", rom_req, m.fetching);
    if (m.fetching) chk("rom_addr", rom_addr, m.pc);
    chk("pc", pc, m.pc);
    chk("halted", halted, m.halted);
    chk("instr_valid", instr_valid, m.since == 0);
    chk("instruction", instruction, (m.since == 0) ? m.word : BUBBLE);
    if (rom_req) begin
      if (wcnt >= cur_lat) begin
        rom_ack = 1'b1; rom_data = mem[rom_addr]; wcnt = 0; cur_lat = pick_lat();
      end else begin
        rom_ack = 1'b0; wcnt++;
      end
    end else begin
      rom_ack  = spur_en && ($urandom_range(0, 9) == 0);
      rom_data = 16'($urandom);
    end
  endtask

  task automatic run_hs(output logic [11:0] a, output int nreq, output int nval, input int budget);
    a = 12'hxxx; nreq = 0; nval = 0;
    for (int i = 0; i < budget; i++) begin
      step();
      if (rom_req) nreq++;
      if (instr_valid) nval++;
      if (rom_req && rom_ack) begin
        a = rom_addr;
        return;
      end
    end
    n_checks++; n_errors++;
    $display("FAIL handshake_timeout: no handshake within %0d cycles (cycle %0d)", budget, cyc);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int vcyc[$];
    logic [15:0] vw[$];
    logic [11:0] ha[$];
    logic [11:0] a, frozen, pc3;
    int nreq, nval, bub_bad, vcount;

    for (int i = 0; i < 4096; i++) mem[i] = 16'($urandom);
    mem[0] = 16'hD105; mem[1] = 16'h0103; mem[2] = 16'hD2FF; mem[5] = 16'hA020;

    // Reset and zero-wait sequential flow.
    set_lat(0);
    rst = 1'b1;
    repeat (2) step();
    chk("reset_rom_req", rom_req, 1'b0);
    chk("reset_pc", pc, RESET_PC);
    chk("reset_valid", instr_valid, 1'b0);
    chk("reset_instruction", instruction, 16'h0000);
    rst = 1'b0;
    bub_bad = 0; pc3 = 12'h0;
    for (int i = 0; i < 12; i++) begin
      step();
      if (rom_req && rom_ack) ha.push_back(rom_addr);
      if (instr_valid) begin
        vcyc.push_back(cyc); vw.push_back(instruction);
        if (vw.size() == 3) pc3 = pc;
      end else if (instruction !== 16'h0000) bub_bad++;
    end
    chk("t1_nfetch", ha.size(), 4);
    chk("t1_npulse", vw.size(), 4);
    if (ha.size() >= 3 && vw.size() >= 3) begin
      chk("t1_addr0", ha[0], 12'h000);
      chk("t1_addr1", ha[1], 12'h001);
      chk("t1_addr2", ha[2], 12'h002);
      chk("t1_word0", vw[0], 16'hD105);
      chk("t1_word1", vw[1], 16'h0103);
      chk("t1_word2", vw[2], 16'hD2FF);
      chk("t1_gap01", vcyc[1] - vcyc[0], 3);
      chk("t1_gap12", vcyc[2] - vcyc[1], 3);
    end
    chk("t1_pc_after3", pc3, 12'h003);
    chk("t1_bubbles", bub_bad, 0);

    // Slow memory: ack arrives four cycles after the request.
    set_lat(4);
    run_hs(a, nreq, nval, 20);
    chk("t2_addr", a, 12'h004);
    chk("t2_req_cycles", nreq, 5);
    run_hs(a, nreq, nval, 20);
    chk("t2_addr_next", a, 12'h005);
    chk("t2_req_cycles_next", nreq, 5);
    chk("t2_one_pulse", nval, 1);

    // Jump taken once although must_jump is held through the next fetch.
    set_lat(0);
    step();
    chk("t3_issue_word", instruction, 16'hA020);
    step();
    must_jump = 1'b1; jump_addr = 12'h020;
    run_hs(a, nreq, nval, 10);
    chk("t3_jump_addr", a, 12'h020);
    step();
    chk("t3_pc_after", pc, 12'h021);
    step();
    must_jump = 1'b0;
    run_hs(a, nreq, nval, 10);
    chk("t3_no_second_jump", a, 12'h021);

    // PC wrap at 12'hFFF.
    step(); step();
    must_jump = 1'b1; jump_addr = 12'hFFF;
    run_hs(a, nreq, nval, 10);
    must_jump = 1'b0;
    chk("t4_fetch_fff", a, 12'hFFF);
    step();
    chk("t4_pc_wrap", pc, 12'h000);
    run_hs(a, nreq, nval, 10);
    chk("t4_next_addr", a, 12'h000);

    // Halt asserted during WAIT.
    vcount = 0;
    step();
    if (instr_valid) vcount++;
    step();
    halt = 1'b1;
    repeat (4) begin step(); if (instr_valid) vcount++; end
    chk("t5_one_issue", vcount, 1);
    chk("t5_halted", halted, 1'b1);
    chk("t5_req_low", rom_req, 1'b0);
    frozen = pc;
    chk("t5_pc_frozen_val", frozen, 12'h001);
    repeat (3) step();
    chk("t5_pc_still", pc, frozen);
    halt = 1'b0;
    run_hs(a, nreq, nval, 10);
    chk("t5_resume_addr", a, 12'h001);

    // Reset while a request at 12'h010 waits for its ack.
    step(); step();
    must_jump = 1'b1; jump_addr = 12'h010;
    set_lat(100);
    step();
    must_jump = 1'b0;
    chk("t6_req_pending", rom_req, 1'b1);
    chk("t6_addr_pending", rom_addr, 12'h010);
    step(); step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("t6_req_dropped", rom_req, 1'b0);
    chk("t6_pc_reset", pc, RESET_PC);
    chk("t6_valid_low", instr_valid, 1'b0);
    rom_ack = 1'b1; rom_data = 16'hBEEF;
    set_lat(0);
    run_hs(a, nreq, nval, 10);
    chk("t6_restart_addr", a, 12'h000);
    chk("t6_no_late_issue", nval, 0);
    step();
    chk("t6_pc_after", pc, 12'h001);

    // Randomized traffic against the model.
    set_lat(-1);
    spur_en = 1'b1;
    for (int i = 0; i < 4000; i++) begin
      step();
      if (rst) begin
        rst = 1'b0;
      end else if ($urandom_range(0, 299) == 0) begin
        rst = 1'b1; wcnt = 0; cur_lat = pick_lat();
      end
      if ($urandom_range(0, 2) == 0) must_jump = ~must_jump;
      jump_addr = ($urandom_range(0, 7) == 0) ? 12'hFFF : 12'($urandom);
      if (halt) begin
        if ($urandom_range(0, 3) == 0) halt = 1'b0;
      end else if ($urandom_range(0, 29) == 0) halt = 1'b1;
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction fetch stage directly upstream of the control unit.
- Owns the 12-bit program counter and fetches 16-bit words from program memory over a req/ack handshake.
- Presents each word to the control unit for exactly one cycle, padded with bubble words otherwise.
- Applies the control unit's registered jump request (must_jump/jump_addr) before the next fetch.

Parameters:
- WAIT_CYCLES, 1, cycles spent in WAIT after each issue before must_jump is sampled (min 1; covers the control unit's registered jump outputs).
- BUBBLE, 16'h0000, word driven on instruction when no valid instruction is being issued.
- RESET_PC, 12'h000, PC value loaded on reset.

Ports:
- clk  input  1  system clock, all state updates on posedge.
- rst  input  1  synchronous, active-high reset.
- rom_addr  output  12  program memory address, equals pc while rom_req=1.
- rom_req  output  1  fetch request to program memory.
- rom_ack  input  1  program memory: rom_data valid this cycle.
- rom_data  input  16  fetched instruction word.
- instruction  output  16  word to control unit; BUBBLE unless instr_valid.
- instr_valid  output  1  high for exactly one cycle per issued instruction.
- must_jump  input  1  jump request from control unit (level).
- jump_addr  input  12  jump target from control unit.
- halt  input  1  stop fetching at next instruction boundary.
- pc  output  12  current program counter.
- halted  output  1  high while in HALTED state.

Behaviour:
- Reset (rst=1 at posedge, any state, including mid-handshake):
  - state=FETCH, pc=RESET_PC, rom_req=0, instr_valid=0, instruction=BUBBLE, halted=0, wait counter=0.
  - rom_req is reasserted the first cycle after rst falls, unless halt=1.
- All outputs are registered, except instruction, which is muxed from the latched word by instr_valid.
- FETCH:
  - Entry check: if halt=1 -> HALTED, no request issued.
  - Otherwise rom_req=1, rom_addr=pc, both held stable until rom_ack.
  - On rom_ack=1 (same cycle rom_req=1): latch rom_data; pc<=pc+1 (mod 4096; 12'hFFF wraps to 12'h000); rom_req<=0; -> ISSUE.
  - rom_ack while rom_req=0 is ignored.
- ISSUE (1 cycle):
  - instr_valid=1, instruction=latched word.
  - Next -> WAIT with counter=WAIT_CYCLES-1.
- WAIT:
  - instr_valid=0, instruction=BUBBLE.
  - Counter decrements each cycle.
  - In the cycle the counter is 0, sample must_jump: if 1, pc<=jump_addr; -> FETCH.
  - must_jump in any other state or cycle is ignored. The control unit holds must_jump high until its next instruction, so level-sampling elsewhere would jump twice.
- HALTED:
  - rom_req=0, halted=1, pc frozen.
  - When halt=0 is sampled -> FETCH (halted=0 next cycle).
- halt in ISSUE/WAIT: takes effect at the next FETCH entry; the current instruction completes, including any jump.
- Minimum throughput: one instruction per (ack latency + 2 + WAIT_CYCLES) cycles. With zero-wait memory (rom_ack the same cycle as rom_req) and WAIT_CYCLES=1, that is 3 cycles per instruction.
- Jump to the current pc+1 value is legal and behaves identically to sequential flow.

Test Plan:
- Reset, zero-wait ROM with mem[0..2]=16'hD105,16'h0103,16'hD2FF, no jumps -> rom_addr 0,1,2 in successive FETCH cycles; instr_valid pulses every 3 cycles with those words; instruction=16'h0000 between pulses; pc ends at 3.
- ROM acks 4 cycles after req -> rom_req and rom_addr stay constant for all 4 cycles; exactly one instr_valid pulse per ack; no extra pc increment.
- mem[5]=16'hA020 and the bench drives must_jump=1, jump_addr=12'h020 from the cycle after that issue, held through the next fetch -> next rom_addr=12'h020, no fetch of address 6, pc=12'h021 after fetch; the held must_jump does not cause a second jump.
- pc=12'hFFF fetch -> pc wraps to 12'h000 and next rom_addr=12'h000.
- halt=1 asserted during WAIT -> current instruction issued once, then halted=1, rom_req=0, pc frozen; halt=0 -> fetch resumes at frozen pc.
- rst=1 while rom_req=1 awaiting ack at pc=12'h010 -> next cycle rom_req=0, pc=RESET_PC, instr_valid=0; a late rom_ack is ignored; fetch restarts at 12'h000.
